// File: rtl/mult_operand_sequencer.sv
// Operand FIFO feeding a pulse-handshake shift-add multiplier; one multiply in flight at a time,
// with the product held in a result register on a valid/ready output stream.
//
// state | meaning
// IDLE  | no multiply in flight; issues the FIFO head when the FIFO is non-empty
// WAIT  | operands held on the multiplier port; waiting for mul_ready or the timeout
// HOLD  | product (or 0 after a timeout) presented until the consumer takes it
module mult_operand_sequencer #(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_a,
    input  logic [N-1:0]            in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*N-1:0]          out_product,
    output logic                    mul_start,
    output logic [N-1:0]            mul_multiplier,
    output logic [N-1:0]            mul_multiplicand,
    input  logic                    mul_ready,
    input  logic [2*N-1:0]          mul_product,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    busy,
    output logic                    err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    mem_a [DEPTH];
    logic [N-1:0]    mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   tmo_cnt;
    logic            in_en;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    // Registered occupancy only: a pop in the same cycle never reopens a full FIFO.
    assign in_ready   = in_en && !fifo_full;
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_en      <= 1'b0;
        end else begin
            in_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            mul_start        <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            tmo_cnt          <= '0;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        mul_multiplier   <= mem_a[rd_ptr];
                        mul_multiplicand <= mem_b[rd_ptr];
                        mul_start        <= 1'b1;
                        tmo_cnt          <= '0;
                        busy             <= 1'b1;
                        state            <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (mul_ready) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // A lost multiply still yields one (zero) result beat to keep counts aligned.
                        err         <= 1'b1;
                        out_product <= '0;
                        out_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
